// File: rtl/semafor_multi_ctrl.sv
// Multi-direction traffic light controller: round-robin vehicle greens, optional pedestrian
// phase after the last direction, and a blinking-yellow service mode.
module semafor_multi_ctrl #(
    parameter int unsigned N_DIR       = 4,
    parameter int unsigned DIV_FACTOR  = 10000000,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_PED       = 12,
    parameter int unsigned T_PED_BLINK = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*N_DIR-1:0] green_sec_i,
    input  logic               ped_req,
    input  logic               service_btn,
    output logic [N_DIR-1:0]   verde,
    output logic [N_DIR-1:0]   galben,
    output logic [N_DIR-1:0]   rosu,
    output logic               verde_pietoni,
    output logic               rosu_pietoni,
    output logic [2:0]         phase_o,
    output logic [2:0]         dir_o,
    output logic [7:0]         sec_left_o
);

    typedef enum logic [2:0] {
        StAllRed   = 3'd0,
        StGreen    = 3'd1,
        StYellow   = 3'd2,
        StPedGreen = 3'd3,
        StPedBlink = 3'd4,
        StService  = 3'd5
    } state_e;

    localparam logic [2:0]       LastDir     = 3'(N_DIR - 1);
    localparam logic [31:0]      PrescMax    = 32'(DIV_FACTOR - 1);
    localparam logic [7:0]       SecYellow   = 8'(T_YELLOW);
    localparam logic [7:0]       SecAllRed   = 8'(T_ALLRED);
    localparam logic [7:0]       SecPed      = 8'(T_PED);
    localparam logic [7:0]       SecPedBlink = 8'(T_PED_BLINK);
    localparam logic [N_DIR-1:0] DirOne      = {{(N_DIR - 1){1'b0}}, 1'b1};

    state_e      r_state, w_state_d;
    logic [2:0]  r_dir, w_dir_d;
    logic [7:0]  r_sec, w_sec_d;
    logic [31:0] r_presc, w_presc_d;
    logic        r_blink, w_blink_d;
    logic        r_ped, w_ped_d;
    logic        r_svc, w_svc_d;
    logic        r_from_yel, w_from_yel_d;

    logic [N_DIR-1:0] r_verde, r_galben, r_rosu;
    logic             r_vp, r_rp;
    logic [N_DIR-1:0] w_verde, w_galben, w_rosu, w_dir_oh;
    logic             w_vp, w_rp;

    logic       w_tick, w_expire;
    logic [2:0] w_next_dir;
    logic [7:0] w_green_sec;

    assign w_tick     = (r_presc == PrescMax);
    assign w_expire   = w_tick && (r_sec == 8'd1);
    assign w_next_dir = (r_dir == LastDir) ? 3'd0 : r_dir + 3'd1;

    // A programmed green of 0 s is served as 1 s.
    always_comb begin
        w_green_sec = 8'd0;
        for (int d = 0; d < N_DIR; d++) begin
            if (w_next_dir == 3'(d)) begin
                w_green_sec = green_sec_i[8*d +: 8];
            end
        end
        if (w_green_sec == 8'd0) begin
            w_green_sec = 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StAllRed;
            r_dir      <= LastDir;
            r_sec      <= SecAllRed;
            r_presc    <= '0;
            r_blink    <= 1'b0;
            r_ped      <= 1'b0;
            r_svc      <= 1'b0;
            r_from_yel <= 1'b0;
            r_verde    <= '0;
            r_galben   <= '0;
            r_rosu     <= '1;
            r_vp       <= 1'b0;
            r_rp       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_dir      <= w_dir_d;
            r_sec      <= w_sec_d;
            r_presc    <= w_presc_d;
            r_blink    <= w_blink_d;
            r_ped      <= w_ped_d;
            r_svc      <= w_svc_d;
            r_from_yel <= w_from_yel_d;
            r_verde    <= w_verde;
            r_galben   <= w_galben;
            r_rosu     <= w_rosu;
            r_vp       <= w_vp;
            r_rp       <= w_rp;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_dir_d      = r_dir;
        w_sec_d      = r_sec;
        w_presc_d    = w_tick ? '0 : r_presc + 32'd1;
        w_blink_d    = w_tick ? ~r_blink : r_blink;
        w_ped_d      = r_ped | ped_req;
        w_svc_d      = r_svc | (service_btn && (r_state != StService));
        w_from_yel_d = r_from_yel;
        if (w_tick && (r_sec > 8'd1)) begin
            w_sec_d = r_sec - 8'd1;
        end
        unique case (r_state)
            StAllRed: begin
                if (w_expire) begin
                    w_presc_d = '0;
                    if (r_svc) begin
                        w_state_d = StService;
                        w_sec_d   = '0;
                        w_blink_d = 1'b1;
                    end else if (r_from_yel && (r_dir == LastDir) && r_ped) begin
                        // A request arriving on this very edge stays pending.
                        w_state_d = StPedGreen;
                        w_sec_d   = SecPed;
                        w_ped_d   = ped_req;
                    end else begin
                        w_state_d = StGreen;
                        w_dir_d   = w_next_dir;
                        w_sec_d   = w_green_sec;
                    end
                end
            end
            StGreen: begin
                if (w_expire) begin
                    w_state_d = StYellow;
                    w_sec_d   = SecYellow;
                    w_presc_d = '0;
                end
            end
            StYellow: begin
                if (w_expire) begin
                    w_state_d    = StAllRed;
                    w_sec_d      = SecAllRed;
                    w_presc_d    = '0;
                    w_from_yel_d = 1'b1;
                end
            end
            StPedGreen: begin
                if (w_expire) begin
                    w_state_d = StPedBlink;
                    w_sec_d   = SecPedBlink;
                    w_presc_d = '0;
                    w_blink_d = 1'b1;
                end
            end
            StPedBlink: begin
                if (w_expire) begin
                    w_state_d    = StAllRed;
                    w_sec_d      = SecAllRed;
                    w_presc_d    = '0;
                    w_from_yel_d = 1'b0;
                end
            end
            StService: begin
                if (service_btn) begin
                    w_state_d    = StAllRed;
                    w_dir_d      = LastDir;
                    w_sec_d      = SecAllRed;
                    w_presc_d    = '0;
                    w_svc_d      = 1'b0;
                    w_from_yel_d = 1'b0;
                end
            end
            default: begin
                w_state_d    = StAllRed;
                w_dir_d      = LastDir;
                w_sec_d      = SecAllRed;
                w_presc_d    = '0;
                w_from_yel_d = 1'b0;
            end
        endcase
    end

    // Lamps are decoded from the next state so the registered outputs track the state.
    always_comb begin
        w_dir_oh = DirOne << w_dir_d;
        w_verde  = '0;
        w_galben = '0;
        w_rosu   = '1;
        w_vp     = 1'b0;
        w_rp     = 1'b0;
        unique case (w_state_d)
            StGreen: begin
                w_verde = w_dir_oh;
                w_rosu  = ~w_dir_oh;
                w_rp    = 1'b1;
            end
            StYellow: begin
                w_galben = w_dir_oh;
                w_rosu   = ~w_dir_oh;
                w_rp     = 1'b1;
            end
            StPedGreen: w_vp = 1'b1;
            StPedBlink: w_vp = w_blink_d;
            StService: begin
                w_rosu   = '0;
                w_galben = {N_DIR{w_blink_d}};
            end
            default: w_rp = 1'b1;
        endcase
    end

    assign verde         = r_verde;
    assign galben        = r_galben;
    assign rosu          = r_rosu;
    assign verde_pietoni = r_vp;
    assign rosu_pietoni  = r_rp;
    assign phase_o       = r_state;
    assign dir_o         = r_dir;
    assign sec_left_o    = r_sec;

endmodule

// File: tb/tb_semafor_multi_ctrl.sv
// Bench for semafor_multi_ctrl: directed scenarios plus random requests, all checked every
// cycle against a cycle-count reference model of the light sequence.
module tb_semafor_multi_ctrl;

    localparam int NDir = 4;
    localparam int Div  = 4;
    localparam int TYel = 3;
    localparam int TAr  = 2;
    localparam int TPed = 2;
    localparam int TPb  = 2;
    localparam int PhAr = 0, PhG = 1, PhY = 2, PhPg = 3, PhPb = 4, PhSvc = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] green_sec_i;
    logic        ped_req, service_btn;
    logic [3:0]  verde, galben, rosu;
    logic        verde_pietoni, rosu_pietoni;
    logic [2:0]  phase_o, dir_o;
    logic [7:0]  sec_left_o;

    always #5 clk = ~clk;

    semafor_multi_ctrl #(
        .N_DIR      (NDir),
        .DIV_FACTOR (Div),
        .T_YELLOW   (TYel),
        .T_ALLRED   (TAr),
        .T_PED      (TPed),
        .T_PED_BLINK(TPb)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .green_sec_i  (green_sec_i),
        .ped_req      (ped_req),
        .service_btn  (service_btn),
        .verde        (verde),
        .galben       (galben),
        .rosu         (rosu),
        .verde_pietoni(verde_pietoni),
        .rosu_pietoni (rosu_pietoni),
        .phase_o      (phase_o),
        .dir_o        (dir_o),
        .sec_left_o   (sec_left_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, direction, cycles left in phase, cycles elapsed in phase.
    int m_phase, m_dir, m_left, m_el;
    bit m_ped, m_svc, m_from_yel;

    int seg_len[$];
    int seg_key[$];
    int cur_len, cur_key;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int green_len(input int d);
        int f;
        f = int'((green_sec_i >> (8 * d)) & 32'hFF);
        return (f == 0) ? 1 : f;
    endfunction

    task automatic model_enter(input int ph, input int secs);
        m_phase = ph;
        m_left  = secs * Div;
        m_el    = 0;
    endtask

    task automatic model_reset();
        model_enter(PhAr, TAr);
        m_dir      = NDir - 1;
        m_ped      = 0;
        m_svc      = 0;
        m_from_yel = 0;
    endtask

    task automatic model_step(input bit pr, input bit sb, input bit rn);
        bit nped, nsvc;
        if (!rn) begin
            model_reset();
            return;
        end
        nped = m_ped | pr;
        nsvc = m_svc | (sb && (m_phase != PhSvc));
        if (m_phase == PhSvc) begin
            m_el++;
            if (sb) begin
                model_enter(PhAr, TAr);
                m_dir      = NDir - 1;
                m_from_yel = 0;
                nsvc       = 0;
            end
        end else if (m_left == 1) begin
            case (m_phase)
                PhAr: begin
                    if (m_svc) begin
                        model_enter(PhSvc, 0);
                    end else if (m_from_yel && m_dir == NDir - 1 && m_ped) begin
                        model_enter(PhPg, TPed);
                        nped = pr;
                    end else begin
                        m_dir = (m_dir + 1) % NDir;
                        model_enter(PhG, green_len(m_dir));
                    end
                end
                PhG:  model_enter(PhY, TYel);
                PhY: begin
                    model_enter(PhAr, TAr);
                    m_from_yel = 1;
                end
                PhPg: model_enter(PhPb, TPb);
                default: begin
                    model_enter(PhAr, TAr);
                    m_from_yel = 0;
                end
            endcase
        end else begin
            m_left--;
            m_el++;
        end
        m_ped = nped;
        m_svc = nsvc;
    endtask

    task automatic compare_all(input bit rn);
        logic [3:0] ev, eg, er, oh;
        logic       evp, erp, blink;
        int         es, key;
        oh    = 4'b0001 << m_dir;
        blink = ((m_el / Div) % 2) == 0;
        ev    = '0;
        eg    = '0;
        er    = 4'hF;
        evp   = 1'b0;
        erp   = 1'b0;
        case (m_phase)
            PhAr: erp = 1'b1;
            PhG: begin
                ev  = oh;
                er  = ~oh;
                erp = 1'b1;
            end
            PhY: begin
                eg  = oh;
                er  = ~oh;
                erp = 1'b1;
            end
            PhPg: evp = 1'b1;
            PhPb: evp = blink;
            default: begin
                er = 4'h0;
                eg = blink ? 4'hF : 4'h0;
            end
        endcase
        es = (m_phase == PhSvc) ? 0 : (m_left + Div - 1) / Div;
        check_val("verde", verde, ev);
        check_val("galben", galben, eg);
        check_val("rosu", rosu, er);
        check_val("verde_pietoni", verde_pietoni, evp);
        check_val("rosu_pietoni", rosu_pietoni, erp);
        check_val("phase", phase_o, m_phase);
        check_val("dir", dir_o, m_dir);
        check_val("sec_left", sec_left_o, es);
        if (m_phase != PhSvc) begin
            check_val("lamp_excl", ($countones(verde | galben) <= 1) &&
                      !(verde_pietoni && ((verde | galben) != 4'h0)), 1);
        end
        key = int'(phase_o) * 8 + int'(dir_o);
        if (!rn) begin
            seg_len.delete();
            seg_key.delete();
            cur_len = 1;
            cur_key = key;
        end else if (key == cur_key) begin
            cur_len++;
        end else begin
            if (cur_len > 0) begin
                seg_len.push_back(cur_len);
                seg_key.push_back(cur_key);
            end
            cur_len = 1;
            cur_key = key;
        end
    endtask

    task automatic step(input bit pr, input bit sb, input bit rn);
        @(negedge clk);
        ped_req     = pr;
        service_btn = sb;
        rst_n       = rn;
        @(posedge clk);
        model_step(pr, sb, rn);
        #1;
        compare_all(rn);
    endtask

    task automatic seg_clear();
        seg_len.delete();
        seg_key.delete();
        cur_len = 0;
        cur_key = -1;
    endtask

    function automatic int seg_len_at(input int i);
        return (i >= 0 && i < seg_len.size()) ? seg_len[i] : -1;
    endfunction

    function automatic int seg_key_at(input int i);
        return (i >= 0 && i < seg_key.size()) ? seg_key[i] : -1;
    endfunction

    function automatic int find_phase(input int ph);
        for (int i = 0; i < seg_key.size(); i++) begin
            if (seg_key[i] / 8 == ph) return i;
        end
        return -1;
    endfunction

    function automatic int count_phase(input int ph);
        int n = 0;
        for (int i = 0; i < seg_key.size(); i++) begin
            if (seg_key[i] / 8 == ph) n++;
        end
        return n;
    endfunction

    task automatic wait_model(input string tag, input int ph, input int dir, input int budget);
        int n = 0;
        while (!(m_phase == ph && (dir < 0 || m_dir == dir)) && n < budget) begin
            step(0, 0, 1);
            n++;
        end
        check_val(tag, (m_phase == ph && (dir < 0 || m_dir == dir)), 1);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, n;
        rst_n       = 1'b0;
        ped_req     = 1'b0;
        service_btn = 1'b0;
        green_sec_i = {8'd2, 8'd0, 8'd1, 8'd5};
        model_reset();
        seg_clear();
        step(0, 0, 0);
        step(0, 0, 0);

        // Full round without requests.
        for (int i = 0; i < 125; i++) step(0, 0, 1);
        check_val("ar_after_reset_len", seg_len_at(0), 8);
        check_val("green0_len", seg_len_at(1), 20);
        check_val("yellow0_len", seg_len_at(2), 12);
        check_val("allred0_len", seg_len_at(3), 8);
        check_val("green1_len", seg_len_at(4), 4);
        check_val("green2_zero_len", seg_len_at(7), 4);
        check_val("green3_len", seg_len_at(10), 8);
        check_val("allred3_key", seg_key_at(12), PhAr * 8 + 3);
        check_val("round_wrap_no_ped", cur_key, PhG * 8 + 0);

        // Pedestrian request during GREEN(1).
        wait_model("reach_g1", PhG, 1, 200);
        seg_clear();
        step(1, 0, 1);
        wait_model("reach_g0_after_ped", PhG, 0, 400);
        idx = find_phase(PhPg);
        check_val("ped_green_len", seg_len_at(idx), 8);
        check_val("ped_blink_key", seg_key_at(idx + 1) / 8, PhPb);
        check_val("ped_blink_len", seg_len_at(idx + 1), 8);
        check_val("ped_allred_len", seg_len_at(idx + 2), 8);
        check_val("ped_then_g0", cur_key, PhG * 8 + 0);

        // Request coincident with PED_GREEN entry is served again next round.
        step(1, 0, 1);
        n = 0;
        while (!(m_phase == PhAr && m_dir == NDir - 1 && m_from_yel && m_left == 1 && m_ped)
               && n < 300) begin
            step(0, 0, 1);
            n++;
        end
        check_val("reach_ped_entry", (m_phase == PhAr && m_left == 1), 1);
        seg_clear();
        step(1, 0, 1);
        wait_model("g0_after_ped_a", PhG, 0, 200);
        wait_model("g1_next_round", PhG, 1, 200);
        wait_model("g0_after_ped_b", PhG, 0, 400);
        check_val("ped_served_twice", count_phase(PhPg), 2);

        // Service request during YELLOW(2).
        wait_model("reach_y2", PhY, 2, 400);
        step(0, 1, 1);
        wait_model("svc_enter", PhSvc, -1, 100);
        check_val("svc_blink_on", galben, 4'hF);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check_val("svc_blink_off", galben, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check_val("svc_blink_on2", galben, 4'hF);
        check_val("svc_sec_left", sec_left_o, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        seg_clear();
        step(0, 1, 1);
        wait_model("svc_exit_g0", PhG, 0, 60);
        check_val("svc_exit_ar_len", seg_len_at(0), 8);
        check_val("svc_exit_ar_key", seg_key_at(0), PhAr * 8 + 3);

        // Reset in the middle of SERVICE.
        step(0, 1, 1);
        wait_model("svc_enter2", PhSvc, -1, 100);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 0, 0);
        check_val("rst_rosu", rosu, 4'hF);
        check_val("rst_galben", galben, 4'h0);
        check_val("rst_phase", phase_o, 0);
        check_val("rst_dir", dir_o, 3);
        wait_model("rst_then_g0", PhG, 0, 60);
        check_val("rst_ar_len", seg_len_at(0), 8);
        check_val("rst_svc_dropped", cur_key, PhG * 8 + 0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int d = 0; d < NDir; d++) green_sec_i[8*d +: 8] = 8'($urandom_range(0, 3));
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 799) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
